// File: rtl/path_count_accumulator.sv
// Kahn-order path-count engine: accumulates per-node path counts and queues finished nodes.
// Optional build macro ACCUM_SATURATE_EN clamps overflowing sums instead of wrapping them.
module path_count_accumulator #(
  parameter int NODE_IDX_WIDTH  = 10,
  parameter int COUNTER_WIDTH   = 4,
  parameter int ACCUM_VAL_WIDTH = 24,
  parameter int FIFO_DEPTH      = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_clear,
  output logic                             busy,
  output logic                             run_active,
  input  logic                             indeg_wr_en,
  output logic                             indeg_ready,
  input  logic [NODE_IDX_WIDTH-1:0]        indeg_wr_idx,
  input  logic [COUNTER_WIDTH-1:0]         indeg_wr_val,
  input  logic                             seed_valid,
  output logic                             seed_ready,
  input  logic [NODE_IDX_WIDTH-1:0]        seed_idx,
  input  logic                             edge_valid,
  output logic                             edge_ready,
  input  logic [NODE_IDX_WIDTH-1:0]        edge_dst_idx,
  input  logic [ACCUM_VAL_WIDTH-1:0]       edge_src_count,
  output logic                             pop_valid,
  input  logic                             pop_ready,
  output logic [NODE_IDX_WIDTH-1:0]        pop_idx,
  output logic [ACCUM_VAL_WIDTH-1:0]       pop_count,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow,
  output logic                             indeg_err
);

  localparam int NUM_NODES = 1 << NODE_IDX_WIDTH;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W:0]   DEPTH_OCC = (LVL_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

  state_t                       state;
  logic [NODE_IDX_WIDTH-1:0]    clear_addr;
  logic [ACCUM_VAL_WIDTH-1:0]   count_ram [NUM_NODES];
  logic [COUNTER_WIDTH-1:0]     indeg_ram [NUM_NODES];

  logic                         s2_valid;
  logic [NODE_IDX_WIDTH-1:0]    s2_dst;
  logic [ACCUM_VAL_WIDTH-1:0]   s2_src;
  logic [ACCUM_VAL_WIDTH-1:0]   s2_count;
  logic [COUNTER_WIDTH-1:0]     s2_indeg;

  logic [NODE_IDX_WIDTH-1:0]    fifo_idx_mem [FIFO_DEPTH];
  logic [ACCUM_VAL_WIDTH-1:0]   fifo_cnt_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [LVL_W-1:0]             level;

  logic                         in_run, s2_err, s2_wr, s2_push, carry;
  logic [ACCUM_VAL_WIDTH:0]     sum_full;
  logic [ACCUM_VAL_WIDTH-1:0]   s2_store, fwd_count, rd_count, push_cnt;
  logic [COUNTER_WIDTH-1:0]     s2_new_indeg, fwd_indeg, rd_indeg;
  logic [NODE_IDX_WIDTH-1:0]    push_idx;
  logic [LVL_W:0]               occupancy;
  logic                         fwd_hit, edge_hs, seed_hs, indeg_hs, pop_hs, push;

  logic                         cnt_we, ind_we;
  logic [NODE_IDX_WIDTH-1:0]    cnt_wa, ind_wa;
  logic [ACCUM_VAL_WIDTH-1:0]   cnt_wd;
  logic [COUNTER_WIDTH-1:0]     ind_wd;

  // start_clear wins over everything in its cycle, so a pending stage-2 update is dropped.
  assign in_run       = (state == RUN) && !start_clear;
  assign s2_err       = s2_valid && (s2_indeg == '0);
  assign s2_wr        = s2_valid && !s2_err && in_run;
  assign sum_full     = {1'b0, s2_count} + {1'b0, s2_src};
  assign carry        = sum_full[ACCUM_VAL_WIDTH];
`ifdef ACCUM_SATURATE_EN
  assign s2_store     = carry ? '1 : sum_full[ACCUM_VAL_WIDTH-1:0];
`else
  assign s2_store     = sum_full[ACCUM_VAL_WIDTH-1:0];
`endif
  assign s2_new_indeg = s2_indeg - COUNTER_WIDTH'(1);
  assign s2_push      = s2_wr && (s2_new_indeg == '0);

  assign occupancy   = {1'b0, level} + (LVL_W + 1)'(s2_valid);
  assign edge_ready  = in_run && (occupancy < DEPTH_OCC);
  assign edge_hs     = edge_valid && edge_ready;
  assign seed_ready  = in_run && !edge_hs && !s2_valid && (level < DEPTH_LVL);
  assign seed_hs     = seed_valid && seed_ready;
  assign indeg_ready = in_run && !edge_hs && !s2_valid && !seed_hs;
  assign indeg_hs    = indeg_wr_en && indeg_ready;

  assign pop_valid  = (state == RUN) && (level != '0);
  assign pop_hs     = pop_valid && pop_ready;
  assign pop_idx    = pop_valid ? fifo_idx_mem[rd_ptr] : '0;
  assign pop_count  = pop_valid ? fifo_cnt_mem[rd_ptr] : '0;
  assign fifo_level = level;

  // A same-node edge right behind stage 2 must see its result, not the stale RAM word.
  assign fwd_hit   = s2_valid && (s2_dst == edge_dst_idx);
  assign fwd_count = s2_err ? s2_count : s2_store;
  assign fwd_indeg = s2_err ? s2_indeg : s2_new_indeg;
  assign rd_count  = fwd_hit ? fwd_count : count_ram[edge_dst_idx];
  assign rd_indeg  = fwd_hit ? fwd_indeg : indeg_ram[edge_dst_idx];

  assign push     = s2_push || seed_hs;
  assign push_idx = s2_push ? s2_dst : seed_idx;
  assign push_cnt = s2_push ? s2_store : ACCUM_VAL_WIDTH'(1);

  always_comb begin
    cnt_we = 1'b0;
    cnt_wa = clear_addr;
    cnt_wd = '0;
    ind_we = 1'b0;
    ind_wa = clear_addr;
    ind_wd = '0;
    if (state == CLEAR) begin
      cnt_we = 1'b1;
      ind_we = 1'b1;
    end else if (s2_wr) begin
      cnt_we = 1'b1;
      cnt_wa = s2_dst;
      cnt_wd = s2_store;
      ind_we = 1'b1;
      ind_wa = s2_dst;
      ind_wd = s2_new_indeg;
    end else if (seed_hs) begin
      cnt_we = 1'b1;
      cnt_wa = seed_idx;
      cnt_wd = ACCUM_VAL_WIDTH'(1);
    end else if (indeg_hs) begin
      ind_we = 1'b1;
      ind_wa = indeg_wr_idx;
      ind_wd = indeg_wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (cnt_we) count_ram[cnt_wa] <= cnt_wd;
    if (ind_we) indeg_ram[ind_wa] <= ind_wd;
    if (push) begin
      fifo_idx_mem[wr_ptr] <= push_idx;
      fifo_cnt_mem[wr_ptr] <= push_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      run_active <= 1'b0;
      clear_addr <= '0;
      s2_valid   <= 1'b0;
      s2_dst     <= '0;
      s2_src     <= '0;
      s2_count   <= '0;
      s2_indeg   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      indeg_err  <= 1'b0;
    end else if (start_clear) begin
      state      <= CLEAR;
      busy       <= 1'b1;
      run_active <= 1'b0;
      clear_addr <= '0;
      s2_valid   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      indeg_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CLEAR: begin
          clear_addr <= clear_addr + NODE_IDX_WIDTH'(1);
          if (clear_addr == '1) begin
            state      <= RUN;
            busy       <= 1'b0;
            run_active <= 1'b1;
          end
        end
        RUN: begin
          s2_valid <= edge_hs;
          if (edge_hs) begin
            s2_dst   <= edge_dst_idx;
            s2_src   <= edge_src_count;
            s2_count <= rd_count;
            s2_indeg <= rd_indeg;
          end
          if (s2_err) indeg_err <= 1'b1;
          if (s2_wr && carry) overflow <= 1'b1;
          if (push) wr_ptr <= wr_ptr + PTR_W'(1);
          if (pop_hs) rd_ptr <= rd_ptr + PTR_W'(1);
          if (push && !pop_hs) level <= level + LVL_W'(1);
          else if (!push && pop_hs) level <= level - LVL_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_count_accumulator.sv
// Scoreboard bench for path_count_accumulator: a node-level model predicts every queue pop.
// Honours ACCUM_SATURATE_EN the same way as the design build.
module tb_path_count_accumulator;

  localparam int NW = 10;
  localparam int CW = 4;
  localparam int AW = 24;
  localparam int FD = 32;
  localparam int LW = 6;
  localparam int K_INDEG = 0;
  localparam int K_SEED  = 1;
  localparam int K_EDGE  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_clear, busy, run_active;
  logic          indeg_wr_en, indeg_ready;
  logic [NW-1:0] indeg_wr_idx;
  logic [CW-1:0] indeg_wr_val;
  logic          seed_valid, seed_ready;
  logic [NW-1:0] seed_idx;
  logic          edge_valid, edge_ready;
  logic [NW-1:0] edge_dst_idx;
  logic [AW-1:0] edge_src_count;
  logic          pop_valid, pop_ready;
  logic [NW-1:0] pop_idx;
  logic [AW-1:0] pop_count;
  logic [LW-1:0] fifo_level;
  logic          overflow, indeg_err;

  typedef struct {
    logic [NW-1:0] idx;
    logic [AW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          head;
  int            checks_total  = 0;
  int            checks_passed = 0;
  int            peak_level    = 0;
  logic [AW-1:0] m_count [0:1023];
  logic [CW-1:0] m_indeg [0:1023];
  logic          m_err, m_ovf;

  path_count_accumulator dut (
    .clk(clk), .rst(rst), .start_clear(start_clear), .busy(busy), .run_active(run_active),
    .indeg_wr_en(indeg_wr_en), .indeg_ready(indeg_ready), .indeg_wr_idx(indeg_wr_idx),
    .indeg_wr_val(indeg_wr_val), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .seed_idx(seed_idx), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_dst_idx(edge_dst_idx), .edge_src_count(edge_src_count), .pop_valid(pop_valid),
    .pop_ready(pop_ready), .pop_idx(pop_idx), .pop_count(pop_count),
    .fifo_level(fifo_level), .overflow(overflow), .indeg_err(indeg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) begin
      m_count[i] = '0;
      m_indeg[i] = '0;
    end
    m_err = 1'b0;
    m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_run_active"}, run_active, 0);
    checkOutput({tag, "_indeg_ready"}, indeg_ready, 0);
    checkOutput({tag, "_seed_ready"}, seed_ready, 0);
    checkOutput({tag, "_edge_ready"}, edge_ready, 0);
    checkOutput({tag, "_pop_valid"}, pop_valid, 0);
    checkOutput({tag, "_pop_idx"}, pop_idx, 0);
    checkOutput({tag, "_pop_count"}, pop_count, 0);
    checkOutput({tag, "_fifo_level"}, fifo_level, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
    checkOutput({tag, "_indeg_err"}, indeg_err, 0);
  endtask

  // Drives one request until accepted, then updates the node model on the handshake.
  task automatic applyStimulus(input int kind, input logic [NW-1:0] idx, input logic [AW-1:0] val);
    bit            ready_seen = 0;
    int            budget = 0;
    logic [AW:0]   sum;
    exp_t          e;
    case (kind)
      K_INDEG: begin indeg_wr_en = 1; indeg_wr_idx = idx; indeg_wr_val = val[CW-1:0]; end
      K_SEED:  begin seed_valid = 1; seed_idx = idx; end
      default: begin edge_valid = 1; edge_dst_idx = idx; edge_src_count = val; end
    endcase
    while (!ready_seen && budget < 200) begin
      @(negedge clk);
      case (kind)
        K_INDEG: ready_seen = indeg_ready;
        K_SEED:  ready_seen = seed_ready;
        default: ready_seen = edge_ready;
      endcase
      @(posedge clk);
      #1;
      budget++;
    end
    indeg_wr_en = 0;
    seed_valid  = 0;
    edge_valid  = 0;
    checkOutput("handshake", ready_seen, 1);
    if (ready_seen) begin
      case (kind)
        K_INDEG: m_indeg[idx] = val[CW-1:0];
        K_SEED: begin
          m_count[idx] = 1;
          e.idx = idx; e.cnt = 1;
          exp_q.push_back(e);
        end
        default: begin
          if (m_indeg[idx] == 0) m_err = 1'b1;
          else begin
            sum = {1'b0, m_count[idx]} + {1'b0, val};
            if (sum[AW]) begin
              m_ovf = 1'b1;
`ifdef ACCUM_SATURATE_EN
              m_count[idx] = {AW{1'b1}};
`else
              m_count[idx] = sum[AW-1:0];
`endif
            end else m_count[idx] = sum[AW-1:0];
            m_indeg[idx] = m_indeg[idx] - 1'b1;
            if (m_indeg[idx] == 0) begin
              e.idx = idx; e.cnt = m_count[idx];
              exp_q.push_back(e);
            end
          end
        end
      endcase
    end
  endtask

  task automatic wait_clear_done(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      n++;
      wait_cycles(1);
    end
    checkOutput({tag, "_busy_cycles"}, n, 1024);
    checkOutput({tag, "_run_active"}, run_active, 1);
  endtask

  always @(negedge clk) begin
    if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
    if (!rst && pop_valid && pop_ready) begin
      checkOutput("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        checkOutput("pop_idx", pop_idx, head.idx);
        checkOutput("pop_count", pop_count, head.cnt);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int drain;
    rst = 1; start_clear = 0; indeg_wr_en = 0; indeg_wr_idx = '0; indeg_wr_val = '0;
    seed_valid = 0; seed_idx = '0; edge_valid = 0; edge_dst_idx = '0; edge_src_count = '0;
    pop_ready = 0;
    model_clear();
    wait_cycles(2);
    check_outputs_zero("reset");
    rst = 0;
    wait_cycles(1);

    start_clear = 1;
    wait_cycles(1);
    start_clear = 0;
    checkOutput("clear_edge_ready", edge_ready, 0);
    checkOutput("clear_pop_valid", pop_valid, 0);
    wait_clear_done("clear1");

    // Seed plus two back-to-back edges into the same destination.
    pop_ready = 1;
    applyStimulus(K_INDEG, 5, 2);
    applyStimulus(K_SEED, 3, 0);
    applyStimulus(K_EDGE, 5, 1);
    applyStimulus(K_EDGE, 5, 1);
    @(negedge clk);
    checkOutput("edge_pop_lat1", pop_valid, 0);
    @(negedge clk);
    checkOutput("edge_pop_lat2", pop_valid, 1);
    wait_cycles(2);

    applyStimulus(K_EDGE, 7, 4);
    wait_cycles(1);
    checkOutput("err_flag", indeg_err, m_err);
    checkOutput("err_level", fifo_level, 0);
    applyStimulus(K_INDEG, 7, 1);
    applyStimulus(K_EDGE, 7, 5);
    wait_cycles(3);

    // Queue fill with the consumer stalled.
    pop_ready = 0;
    peak_level = 0;
    for (int i = 0; i < 36; i++) applyStimulus(K_INDEG, NW'(100 + i), 1);
    for (int i = 0; i < 32; i++) applyStimulus(K_EDGE, NW'(100 + i), AW'(i + 1));
    wait_cycles(3);
    checkOutput("fill_level", fifo_level, 32);
    checkOutput("fill_edge_ready", edge_ready, 0);
    checkOutput("fill_seed_ready", seed_ready, 0);
    pop_ready = 1;
    for (int i = 32; i < 36; i++) applyStimulus(K_EDGE, NW'(100 + i), AW'(i + 1));
    drain = 0;
    while (exp_q.size() != 0 && drain < 200) begin
      drain++;
      wait_cycles(1);
    end
    wait_cycles(2);
    checkOutput("fill_drained_level", fifo_level, 0);
    checkOutput("fill_scoreboard_empty", exp_q.size(), 0);
    checkOutput("fill_peak", peak_level, 32);

    checkOutput("ovf_before", overflow, m_ovf);
    applyStimulus(K_INDEG, 200, 2);
    applyStimulus(K_EDGE, 200, 24'hFFFFFF);
    applyStimulus(K_EDGE, 200, 1);
    wait_cycles(3);
    checkOutput("ovf_flag", overflow, m_ovf);

    // Abort mid-stream: the pending stage-2 push must vanish.
    applyStimulus(K_INDEG, 300, 1);
    applyStimulus(K_EDGE, 300, 9);
    start_clear = 1;
    model_clear();
    wait_cycles(1);
    start_clear = 0;
    checkOutput("abort_busy", busy, 1);
    checkOutput("abort_level", fifo_level, 0);
    checkOutput("abort_overflow", overflow, m_ovf);
    checkOutput("abort_indeg_err", indeg_err, m_err);
    wait_clear_done("clear2");
    checkOutput("abort_level_after", fifo_level, 0);
    applyStimulus(K_SEED, 300, 0);
    wait_cycles(3);
    applyStimulus(K_EDGE, 300, 2);
    wait_cycles(2);
    checkOutput("abort_err_after", indeg_err, m_err);
    checkOutput("abort_scoreboard_empty", exp_q.size(), 0);

    pop_ready = 0;
    applyStimulus(K_SEED, 400, 0);
    wait_cycles(1);
    checkOutput("rst_mid_level_before", fifo_level, 1);
    #2 rst = 1;
    exp_q.delete();
    wait_cycles(1);
    check_outputs_zero("rst_mid");
    rst = 0;
    seed_valid = 1;
    wait_cycles(2);
    checkOutput("rst_idle_seed_ready", seed_ready, 0);
    checkOutput("rst_idle_run_active", run_active, 0);
    checkOutput("rst_idle_busy", busy, 0);
    seed_valid = 0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
